// File: rtl/ts_conv_sched.sv
// Temperature-sensor conversion sequencer: settle, start, sample, average, trim.
// Optional macro TS_TIMEOUT_EN adds a per-sample DETOK watchdog in CONV.
module ts_conv_sched #(
   parameter int TDH         = 1,
   parameter int CLK_DIV     = 25,
   parameter int SETTLE_CYC  = 64,
   parameter int NSAMP_LOG2  = 4,
   parameter int TIMEOUT_CYC = 4095
) (
   input  logic       clk,
   input  logic       RSTn,
   input  logic       FLOCK,
   input  logic       reg_ts_en_sel,
   input  logic [7:0] reg_ts_period,
   input  logic       ts_req,
   input  logic [3:0] reg_offset,
   input  logic       A2D_TS_DETOK,
   input  logic [7:0] A2D_TS_DOUT,
   output logic       D2A_TS_EN,
   output logic       D2A_TS_START_EN,
   output logic       D2A_TS_CLK,
   output logic       D2A_TS_CHOPPER_CLK,
   output logic       ts_busy,
   output logic [7:0] ts_data,
   output logic       ts_valid,
   output logic       ts_timeout
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETTLE = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_CONV   = 3'd3;
   localparam logic [2:0] S_ACC    = 3'd4;

   localparam int AW = 8 + NSAMP_LOG2;
   localparam logic [15:0] SET_END = 16'(SETTLE_CYC - 1);
   localparam logic [15:0] STA_END = 16'(2 * CLK_DIV - 1);
   localparam logic [15:0] DIV_END = 16'(CLK_DIV - 1);
   localparam logic [NSAMP_LOG2-1:0] LAST = '1;

   if (TDH < 0 || CLK_DIV < 1 || SETTLE_CYC < 1 ||
       NSAMP_LOG2 < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("ts_conv_sched: invalid parameter set");
   end

   logic [2:0]            state;
   logic [2:0]            state_nx;
   logic [15:0]           cyc;
   logic [15:0]           div;
   logic [7:0]            per_act;
   logic [17:0]           per_cnt;
   logic [2:0]            det_s;
   logic [NSAMP_LOG2-1:0] samp;
   logic [AW-1:0]         acc;
   logic [7:0]            avg;
   logic [9:0]            sum;
   logic [7:0]            sat;
   logic en_ok, per_wrap, trig, accept, abort;
   logic det_edge, capture, last, tmo_hit;

   assign en_ok    = reg_ts_en_sel ? FLOCK : 1'b1;
   assign per_wrap = (per_act != 8'd0) &&
                     (per_cnt == {per_act - 8'd1, 10'h3FF});
   assign trig     = ts_req | per_wrap;
   assign accept   = (state == S_IDLE) & trig & en_ok;
   assign abort    = (state != S_IDLE) & ~en_ok;
   assign det_edge = det_s[1] & ~det_s[2];
   assign capture  = (state == S_CONV) & det_edge;
   assign last     = capture & (samp == LAST);

   // Sign-extended trim; negative sums land above 511 in 10 bits.
   assign avg = acc[AW-1:NSAMP_LOG2];
   assign sum = {2'b00, avg} + {{6{reg_offset[3]}}, reg_offset};
   assign sat = sum[9] ? 8'h00 : (sum[8] ? 8'hFF : sum[7:0]);

`ifdef TS_TIMEOUT_EN
   localparam logic [15:0] TMO_END = 16'(TIMEOUT_CYC - 1);
   logic [15:0] tcnt;

   assign tmo_hit = (state == S_CONV) & ~det_edge & (tcnt == TMO_END);

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         tcnt       <= '0;
         ts_timeout <= 1'b0;
      end else begin
         if (state != S_CONV || det_edge) tcnt <= '0;
         else tcnt <= tcnt + 16'd1;
         if (accept) ts_timeout <= 1'b0;
         else if (tmo_hit & ~abort) ts_timeout <= 1'b1;
      end
   end
`else
   assign tmo_hit    = 1'b0;
   assign ts_timeout = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (accept) state_nx = S_SETTLE;
         S_SETTLE: if (cyc == SET_END) state_nx = S_START;
         S_START:  if (cyc == STA_END) state_nx = S_CONV;
         S_CONV: begin
            if (last) state_nx = S_ACC;
            else if (tmo_hit) state_nx = S_IDLE;
         end
         S_ACC:    state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
      if (abort) state_nx = S_IDLE;
   end

   // Period counter: a new period value is latched only at wrap.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         per_act <= 8'd0;
         per_cnt <= '0;
      end else if (reg_ts_period == 8'd0) begin
         per_act <= 8'd0;
         per_cnt <= '0;
      end else if (per_act == 8'd0 || per_wrap) begin
         per_act <= reg_ts_period;
         per_cnt <= '0;
      end else begin
         per_cnt <= per_cnt + 18'd1;
      end
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state <= S_IDLE;
         cyc   <= '0;
         det_s <= '0;
      end else begin
         state <= state_nx;
         det_s <= {det_s[1:0], A2D_TS_DETOK};
         if (state_nx == state &&
             (state == S_SETTLE || state == S_START))
            cyc <= cyc + 16'd1;
         else
            cyc <= '0;
      end
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         div        <= '0;
         D2A_TS_CLK <= 1'b0;
      end else if (state_nx != S_CONV || state != S_CONV) begin
         div        <= '0;
         D2A_TS_CLK <= 1'b0;
      end else if (div == DIV_END) begin
         div        <= '0;
         D2A_TS_CLK <= ~D2A_TS_CLK;
      end else begin
         div <= div + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         acc                <= '0;
         samp               <= '0;
         D2A_TS_CHOPPER_CLK <= 1'b0;
      end else begin
         if (accept) begin
            acc  <= '0;
            samp <= '0;
         end else if (capture) begin
            acc  <= acc + AW'(A2D_TS_DOUT);
            samp <= samp + 1'b1;
         end
         if (state_nx == S_IDLE) D2A_TS_CHOPPER_CLK <= 1'b0;
         else if (capture) D2A_TS_CHOPPER_CLK <= ~D2A_TS_CHOPPER_CLK;
      end
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         D2A_TS_EN       <= 1'b0;
         D2A_TS_START_EN <= 1'b0;
         ts_busy         <= 1'b0;
         ts_data         <= 8'h00;
         ts_valid        <= 1'b0;
      end else begin
         D2A_TS_EN       <= state_nx != S_IDLE;
         D2A_TS_START_EN <= state_nx == S_START;
         ts_busy         <= state_nx != S_IDLE;
         ts_valid        <= (state == S_ACC) & ~abort;
         if ((state == S_ACC) & ~abort) ts_data <= sat;
      end
   end

endmodule
